// File: rtl/tic_tac_toe_pkg.sv
// Shared types and constants for the tic-tac-toe engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tic_tac_toe_pkg;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;

    // Two bits per cell; 2'b11 is never stored.
    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        MARK_X = 2'b01,
        MARK_O = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_X    = 2'b01,
        WIN_O    = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    localparam logic PLAYER_X = 1'b0;
    localparam logic PLAYER_O = 1'b1;

    // Cell i lives in board[i]; row-major, 0..2 is the top row.
    typedef logic [NUM_CELLS-1:0][1:0] board_t;

    // Every line that wins when its three cells carry the same mark.
    localparam int WIN_LINES [NUM_LINES][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

endpackage

// File: rtl/tic_tac_toe_win_check.sv
// Classifies a board as no result, X win, O win or draw.
// Latency: purely combinational.
// Backpressure: none.
module tic_tac_toe_win_check
    import tic_tac_toe_pkg::*;
(
    input  board_t     board,
    output logic [1:0] result
);

    logic x_win;
    logic o_win;
    logic full;

    // Scan all lines for three equal marks and the board for free cells.
    always_comb begin
        x_win = 1'b0;
        o_win = 1'b0;
        full  = 1'b1;
        for (int l = 0; l < NUM_LINES; l++) begin
            if (board[WIN_LINES[l][0]] == board[WIN_LINES[l][1]] &&
                board[WIN_LINES[l][1]] == board[WIN_LINES[l][2]]) begin
                if (board[WIN_LINES[l][0]] == MARK_X) x_win = 1'b1;
                if (board[WIN_LINES[l][0]] == MARK_O) o_win = 1'b1;
            end
        end
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (board[i] == EMPTY) full = 1'b0;
        end
    end

    // A win on the last free cell must outrank the draw.
    always_comb begin
        result = WIN_NONE;
        if (x_win)      result = WIN_X;
        else if (o_win) result = WIN_O;
        else if (full)  result = WIN_DRAW;
    end

endmodule

// File: rtl/tic_tac_toe.sv
// Two-player 3x3 game engine: holds the board and turn, scores each move.
// Latency: an accepted move is visible on all outputs one clk edge after place is sampled.
// Backpressure: none; illegal or late requests are silently dropped.
module tic_tac_toe
    import tic_tac_toe_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cell_select,
    input  logic       place,
    output logic       current_player,
    output logic       game_over,
    output logic [1:0] winner
);

    board_t     board_q;
    board_t     board_d;
    logic       player_q;
    logic [1:0] winner_q;
    logic [1:0] wc_result;
    logic       sel_empty;
    logic       accept;

    // Is the addressed cell free? Out-of-range selects never match a cell.
    always_comb begin
        sel_empty = 1'b0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (cell_select == 4'(i)) sel_empty = (board_q[i] == EMPTY);
        end
    end

    assign accept = place && !game_over && (cell_select <= 4'd8) && sel_empty;

    // Post-move board, which the scorer sees in the same cycle.
    always_comb begin
        board_d = board_q;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (accept && cell_select == 4'(i)) begin
                board_d[i] = (player_q == PLAYER_X) ? MARK_X : MARK_O;
            end
        end
    end

    tic_tac_toe_win_check u_win_check (
        .board  (board_d),
        .result (wc_result)
    );

    // Game state commits only on accepted moves, so a finished game stays frozen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            board_q  <= '0;
            player_q <= PLAYER_X;
            winner_q <= WIN_NONE;
        end else if (accept) begin
            board_q  <= board_d;
            player_q <= ~player_q;
            winner_q <= wc_result;
        end
    end

    assign current_player = player_q;
    assign winner         = winner_q;
    assign game_over      = (winner_q != WIN_NONE);

endmodule

// File: tb/tb_tic_tac_toe.sv
// Self-checking bench for tic_tac_toe: directed games plus random play against a reference model.
// Latency: model advances on each rising edge, outputs compared on each falling edge.
// Backpressure: n/a.
module tb_tic_tac_toe;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] cell_select = 4'd0;
    logic       place = 1'b0;
    logic       current_player;
    logic       game_over;
    logic [1:0] winner;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // Reference state: 0 empty, 1 X, 2 O; winner 0 none, 1 X, 2 O, 3 draw.
    int m_cells [9];
    int m_player;
    int m_win;

    tic_tac_toe dut (
        .clk            (clk),
        .reset          (reset),
        .cell_select    (cell_select),
        .place          (place),
        .current_player (current_player),
        .game_over      (game_over),
        .winner         (winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit line3(input int a, input int b, input int c, input int mark);
        return m_cells[a] == mark && m_cells[b] == mark && m_cells[c] == mark;
    endfunction

    function automatic int model_result();
        int free;
        for (int mark = 1; mark <= 2; mark++) begin
            for (int r = 0; r < 3; r++) begin
                if (line3(3*r, 3*r+1, 3*r+2, mark)) return mark;
                if (line3(r, r+3, r+6, mark)) return mark;
            end
            if (line3(0, 4, 8, mark) || line3(2, 4, 6, mark)) return mark;
        end
        free = 0;
        for (int i = 0; i < 9; i++) if (m_cells[i] == 0) free++;
        return (free == 0) ? 3 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) m_cells[i] = 0;
        m_player = 0;
        m_win = 0;
    endtask

    // Drive one cycle of inputs, then advance the model over the edge.
    task automatic step(input bit p, input int sel);
        @(negedge clk);
        place = p;
        cell_select = 4'(sel);
        @(posedge clk);
        if (p && m_win == 0 && sel <= 8) begin
            if (m_cells[sel] == 0) begin
                m_cells[sel] = m_player + 1;
                m_player ^= 1;
                m_win = model_result();
            end
        end
        #1;
    endtask

    // Reset pulse placed between edges; outputs must clear before any edge.
    task automatic reset_mid();
        @(negedge clk);
        place = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("async_reset_player", int'(current_player), 0);
        check("async_reset_over", int'(game_over), 0);
        check("async_reset_winner", int'(winner), 0);
        #1 reset = 1'b0;
    endtask

    task automatic expect_out(input string name, input int cp, input int go, input int w);
        check({name, "_player"}, int'(current_player), cp);
        check({name, "_over"}, int'(game_over), go);
        check({name, "_winner"}, int'(winner), w);
    endtask

    task automatic play(input int seq [], input string name);
        foreach (seq[k]) step(1'b1, seq[k]);
        step(1'b0, 0);
    endtask

    // Continuous comparison against the model whenever outputs are settled.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_player", int'(current_player), m_player);
            check("cyc_winner", int'(winner), m_win);
            check("cyc_over", int'(game_over), int'(m_win != 0));
        end
    end

    initial begin
        int sel;
        model_reset();
        #1 reset = 1'b1;
        #3 reset = 1'b0;
        #1;
        chk_en = 1'b1;
        expect_out("reset", 0, 0, 0);

        // Row win for X, turn alternation after each move.
        step(1'b1, 0); expect_out("row_m1", 1, 0, 0);
        step(1'b1, 3); expect_out("row_m2", 0, 0, 0);
        step(1'b1, 1); expect_out("row_m3", 1, 0, 0);
        step(1'b1, 4); expect_out("row_m4", 0, 0, 0);
        step(1'b1, 2); expect_out("row_win", 1, 1, 1);
        // Frozen after the win.
        step(1'b1, 5); expect_out("frozen", 1, 1, 1);
        step(1'b1, 8); expect_out("frozen2", 1, 1, 1);
        reset_mid();
        step(1'b0, 0); expect_out("after_reset", 0, 0, 0);

        // Column win for O on 1,4,7.
        play('{0, 1, 3, 4, 8, 7}, "col");
        expect_out("col_win", 0, 1, 2);
        reset_mid();

        // Diagonal 2,4,6 for X.
        play('{2, 0, 4, 1, 6}, "diag");
        expect_out("diag_win", 1, 1, 1);
        reset_mid();

        // Draw.
        play('{0, 1, 2, 4, 3, 5, 7, 6, 8}, "draw");
        expect_out("draw", 1, 1, 3);
        reset_mid();

        // Win on the ninth move outranks the draw.
        play('{0, 1, 3, 2, 4, 6, 7, 8, 5}, "win9");
        expect_out("win9", 1, 1, 1);
        reset_mid();

        // Illegal requests.
        step(1'b1, 4); expect_out("legal", 1, 0, 0);
        step(1'b1, 4); expect_out("occupied", 1, 0, 0);
        step(1'b1, 9); expect_out("sel9", 1, 0, 0);
        step(1'b1, 15); expect_out("sel15", 1, 0, 0);
        step(1'b1, 0); step(1'b1, 0); step(1'b1, 0);
        expect_out("held3", 0, 0, 0);
        reset_mid();

        // Random play with occasional mid-cycle resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) < 2 || (m_win != 0 && $urandom_range(0, 9) < 3)) begin
                reset_mid();
            end else begin
                if ($urandom_range(0, 9) == 0) sel = int'($urandom_range(9, 15));
                else sel = int'($urandom_range(0, 8));
                step($urandom_range(0, 3) != 0, sel);
            end
        end

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
